// File: rtl/fetch_receive_if.sv
// Fetch-side request/response and decode-side presentation signals, bundled for fetch_receive.
// The slave modport is the receive block; the master modport is whoever drives it.
interface fetch_receive_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    logic [ADDRESS_BITS-1:0] issue_PC;
    logic                    issue_valid;
    logic [DATA_WIDTH-1:0]   i_mem_data;
    logic                    i_mem_valid;
    logic                    flush;
    logic                    stall;
    logic [DATA_WIDTH-1:0]   instruction;
    logic [ADDRESS_BITS-1:0] inst_PC;
    logic                    inst_valid;
    logic                    issue_stall;

    modport master (
        output issue_PC, issue_valid, i_mem_data, i_mem_valid, flush, stall,
        input  instruction, inst_PC, inst_valid, issue_stall
    );

    modport slave (
        input  issue_PC, issue_valid, i_mem_data, i_mem_valid, flush, stall,
        output instruction, inst_PC, inst_valid, issue_stall
    );
endinterface

// File: rtl/fetch_receive.sv
// Matches in-order instruction-memory responses to their request PCs and buffers them for decode.
// Responses belonging to requests issued before a flush are discarded without a separate counter.
module fetch_receive #(
    parameter int                    CORE         = 0,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDRESS_BITS = 32,
    parameter logic [DATA_WIDTH-1:0] NOP          = 32'h00000013
) (
    input logic            clock,
    input logic            reset,
    fetch_receive_if.slave bus
);

    if (CORE < 0 || DATA_WIDTH < 1 || ADDRESS_BITS < 1) begin : g_param_check
        $error("fetch_receive: invalid parameters");
    end

    logic [1:0]              pending;
    logic [ADDRESS_BITS-1:0] pcq [2];
    logic                    pcq_rd, pcq_wr;
    logic [1:0]              pcq_cnt;
    logic [ADDRESS_BITS-1:0] of_pc [2];
    logic [DATA_WIDTH-1:0]   of_data [2];
    logic                    of_rd, of_wr;
    logic [1:0]              of_cnt;

    logic       issue_stall_i;
    logic       inst_valid_i;
    logic       fire, resp, accept, pop, pcq_push;
    logic [1:0] squashed;

    // Requests outstanding but no longer tracked in the PC queue are the squashed ones.
    always_comb begin
        issue_stall_i = ({1'b0, pending} + {1'b0, of_cnt}) >= 3'd2;
        inst_valid_i  = (of_cnt != 2'd0) && !bus.flush;
        fire          = bus.issue_valid && !issue_stall_i;
        resp          = bus.i_mem_valid && (pending != 2'd0);
        squashed      = pending - pcq_cnt;
        accept        = resp && !bus.flush && (squashed == 2'd0);
        pcq_push      = fire && !bus.flush;
        pop           = inst_valid_i && !bus.stall;
    end

    assign bus.issue_stall = issue_stall_i;
    assign bus.inst_valid  = inst_valid_i;
    assign bus.instruction = inst_valid_i ? of_data[of_rd] : NOP;
    assign bus.inst_PC     = inst_valid_i ? of_pc[of_rd] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 2'd0;
            pcq_rd  <= 1'b0;
            pcq_wr  <= 1'b0;
            pcq_cnt <= 2'd0;
            of_rd   <= 1'b0;
            of_wr   <= 1'b0;
            of_cnt  <= 2'd0;
        end else begin
            case ({fire, resp})
                2'b10:   pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: pending <= pending;
            endcase

            if (bus.flush) begin
                pcq_rd  <= 1'b0;
                pcq_wr  <= 1'b0;
                pcq_cnt <= 2'd0;
                of_rd   <= 1'b0;
                of_wr   <= 1'b0;
                of_cnt  <= 2'd0;
            end else begin
                if (pcq_push) pcq_wr <= ~pcq_wr;
                if (accept)   pcq_rd <= ~pcq_rd;
                pcq_cnt <= pcq_cnt + {1'b0, pcq_push} - {1'b0, accept};
                if (accept)   of_wr <= ~of_wr;
                if (pop)      of_rd <= ~of_rd;
                of_cnt <= of_cnt + {1'b0, accept} - {1'b0, pop};
            end
        end
    end

    // Storage carries no reset; occupancy counters alone decide what is live.
    always_ff @(posedge clock) begin
        if (pcq_push) pcq[pcq_wr] <= bus.issue_PC;
        if (accept) begin
            of_pc[of_wr]   <= pcq[pcq_rd];
            of_data[of_wr] <= bus.i_mem_data;
        end
    end

endmodule

// File: tb/tb_fetch_receive.sv
// Directed-vector bench for fetch_receive: streaming, backpressure, flush, reset and stray responses.
module tb_fetch_receive;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clock = 1'b0;
    logic reset;
    int   n_asserts = 0;
    int   n_fail    = 0;

    fetch_receive_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) bus ();

    fetch_receive #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(32), .NOP(NOP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic mv,
                         input logic [31:0] md, input logic fl, input logic st);
        bus.issue_valid = iv;
        bus.issue_PC    = pc;
        bus.i_mem_valid = mv;
        bus.i_mem_data  = md;
        bus.flush       = fl;
        bus.stall       = st;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected presentation: valid with (pc, ins), or the idle NOP/0 pattern.
    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins);
        check({tag, ".valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
        check({tag, ".pc"},    bus.inst_PC,     v ? pc : 32'd0);
        check({tag, ".inst"},  bus.instruction, v ? ins : NOP);
    endtask

    task automatic expect_stall(input string tag, input logic s);
        check({tag, ".issue_stall"}, {31'd0, bus.issue_stall}, {31'd0, s});
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        expect_out("reset", 0, 0, 0);
        expect_stall("reset", 0);
        reset = 1'b0;

        // Streaming with 1-cycle memory latency.
        drive(1, 32'h0, 0, 0, 0, 0);
        expect_stall("st0", 0);
        expect_out("st0", 0, 0, 0);
        tick();
        drive(1, 32'h4, 1, 32'hA, 0, 0);
        expect_stall("st1", 0);
        expect_out("st1", 0, 0, 0);
        tick();
        drive(0, 0, 1, 32'hB, 0, 0);
        expect_out("st2", 1, 32'h0, 32'hA);
        expect_stall("st2", 1);
        tick();
        drive(1, 32'h8, 0, 0, 0, 0);
        expect_out("st3", 1, 32'h4, 32'hB);
        expect_stall("st3", 0);
        tick();
        drive(0, 0, 1, 32'hC, 0, 0);
        expect_out("st4", 0, 0, 0);
        expect_stall("st4", 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_out("st5", 1, 32'h8, 32'hC);
        tick();
        expect_out("st6", 0, 0, 0);

        // Backpressure: decode stalled while responses return.
        drive(1, 32'h0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h4, 1, 32'hA, 0, 1);
        expect_stall("bp1", 0);
        tick();
        drive(0, 0, 1, 32'hB, 0, 1);
        expect_out("bp2", 1, 32'h0, 32'hA);
        expect_stall("bp2", 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        expect_out("bp3", 1, 32'h0, 32'hA);
        expect_stall("bp3", 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_out("bp4", 1, 32'h0, 32'hA);
        tick();
        expect_out("bp5", 1, 32'h4, 32'hB);
        expect_stall("bp5", 0);
        tick();
        expect_out("bp6", 0, 0, 0);

        // Flush with two requests in flight.
        drive(1, 32'h10, 0, 0, 0, 0);
        tick();
        drive(1, 32'h14, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        expect_out("fl2", 0, 0, 0);
        expect_stall("fl2", 1);
        tick();
        drive(0, 0, 1, 32'hD, 0, 0);
        tick();
        drive(0, 0, 1, 32'hE, 0, 0);
        expect_out("fl4", 0, 0, 0);
        tick();
        drive(1, 32'h80, 0, 0, 0, 0);
        expect_out("fl5", 0, 0, 0);
        expect_stall("fl5", 0);
        tick();
        drive(0, 0, 1, 32'hF, 0, 0);
        expect_out("fl6", 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_out("fl7", 1, 32'h80, 32'hF);
        tick();

        // Flush, response and fire in one cycle.
        drive(1, 32'h20, 0, 0, 0, 0);
        tick();
        drive(1, 32'h24, 1, 32'h11, 1, 0);
        expect_out("sim1", 0, 0, 0);
        expect_stall("sim1", 0);
        tick();
        drive(0, 0, 1, 32'h22, 0, 0);
        expect_out("sim2", 0, 0, 0);
        expect_stall("sim2", 0);
        tick();

        // Stray response with nothing pending, then normal traffic.
        drive(0, 0, 1, 32'h33, 0, 0);
        expect_out("stray0", 0, 0, 0);
        tick();
        drive(1, 32'h30, 0, 0, 0, 0);
        expect_out("stray1", 0, 0, 0);
        expect_stall("stray1", 0);
        tick();
        drive(0, 0, 1, 32'h44, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        expect_out("stray3", 1, 32'h30, 32'h44);
        drive(0, 0, 0, 0, 1, 1);
        expect_out("flvalid", 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_out("flclr", 0, 0, 0);

        // Reset with a request pending and an instruction buffered.
        drive(1, 32'h40, 0, 0, 0, 1);
        tick();
        drive(1, 32'h44, 1, 32'h55, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        expect_out("rst0", 1, 32'h40, 32'h55);
        expect_stall("rst0", 1);
        reset = 1'b1;
        drive(1, 32'h48, 1, 32'h66, 0, 1);
        tick();
        reset = 1'b0;
        drive(0, 0, 1, 32'h77, 0, 0);
        expect_out("rst1", 0, 0, 0);
        expect_stall("rst1", 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_out("rst2", 0, 0, 0);
        expect_stall("rst2", 0);
        drive(1, 32'h50, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 32'h88, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        expect_out("rst3", 1, 32'h50, 32'h88);
        tick();
        expect_out("rst4", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
